heat_map_rect_fill: RTL and testbench
=====================================

// Module: heat_map_rect_fill
// PURPOSE
//  Avalon-MM controlled rectangle-fill sequencer for the HPS-to-VGA heat map. HPS loads origin,
//  size and colour into slave registers, then starts a fill. The block walks the clipped
//  rectangle row-major and issues one Avalon-MM master write per pixel into the VGA pixel
//  buffer. It replaces per-pixel HPS coordinate/colour PIO writes.
// PARAMETERS
//  COORD_W     10            width of x/y/width/height fields
//  COLOR_W     16            pixel data width (m_writedata)
//  ADDR_W      32            master address width
//  PIXEL_BASE  32'hC8000000  pixel buffer base address
//  X_SHIFT     1             byte-address shift applied to x
//  Y_SHIFT     10            byte-address shift applied to y
//  SCREEN_W    320           visible columns; x >= SCREEN_W is clipped
//  SCREEN_H    240           visible rows; y >= SCREEN_H is clipped
// PORTS
//  clk           in   1        system clock; the only clock
//  reset         in   1        asynchronous, active-high reset
//  address       in   3        slave register index
//  chipselect    in   1        slave select
//  write_n       in   1        slave write strobe, active low
//  writedata     in   32       slave write data
//  readdata      out  32       slave read data; combinational, zero wait states
//  m_address     out  ADDR_W   pixel write address
//  m_write       out  1        pixel write request
//  m_writedata   out  COLOR_W  pixel colour
//  m_waitrequest in   1        slave stall; a write completes on m_write & !m_waitrequest
//  busy          out  1        fill in progress (for LED/IRQ use)
// BEHAVIOUR
//  Registers: 0 X0, 1 Y0, 2 WIDTH, 3 HEIGHT (COORD_W LSBs each), 4 COLOR (COLOR_W LSBs),
//   5 CTRL. CTRL write: bit0 START, bit1 ABORT. CTRL read: bit0 busy, bit1 done (sticky),
//   bit2 aborted (sticky). Unused read bits and unmapped addresses return 0.
//  Register 0-4 writes are ignored while busy.
//  Reset: all registers, done and aborted clear to 0; m_write=0; m_address=PIXEL_BASE;
//   m_writedata=0; busy=0; FSM in IDLE. Reset mid-fill drops m_write immediately.
//  FSM: IDLE -> SETUP on START (START is ignored outside IDLE). START clears done and aborted.
//   SETUP (1 cycle): xe=min(X0+WIDTH,SCREEN_W), ye=min(Y0+HEIGHT,SCREEN_H), computed at
//   COORD_W+1 bits so there is no overflow. If X0>=SCREEN_W, Y0>=SCREEN_H, WIDTH==0 or
//   HEIGHT==0 -> DONE with no writes. Otherwise x=X0, y=Y0 -> WRITE.
//   WRITE: m_write=1, m_address=PIXEL_BASE+(y<<Y_SHIFT)+(x<<X_SHIFT), m_writedata=COLOR.
//   Address and data stay stable while m_waitrequest=1. On accept: if x+1<xe then x++;
//   else if y+1<ye then x=X0, y++; else -> DONE. Back-to-back accepts give 1 pixel/cycle.
//   DONE (1 cycle): set done, m_write=0 -> IDLE. busy=1 in SETUP, WRITE and DONE.
//  ABORT: in WRITE it takes effect at the next accept. That pixel completes, then go to DONE
//   and set aborted. A write is never dropped mid-handshake. ABORT in IDLE is ignored.
//  START and ABORT in the same CTRL write: START wins in IDLE; ABORT wins when busy.
//  Address arithmetic is ADDR_W wide with no saturation.
// STRUCTURE
//  Shared package heat_map_pkg holds register index localparams (REG_X0..REG_CTRL), CTRL bit
//   positions and the FSM state encoding. The VGA geometry defaults also live there.
//  Optional sub-module heat_map_rect_walker holds the x/y counters, end-bound compare and
//   address computation. The top level keeps the slave register file and the FSM.
// TESTING
//  X0=3,Y0=5,W=2,H=2,COLOR=16'hF800, START, waitrequest=0 -> 4 writes in order
//   (3,5),(4,5),(3,6),(4,6). First address C8001406. done=1 one cycle after the last accept.
//  Same fill with waitrequest high 3 cycles on write 2 -> address/data held; still 4 writes total.
//  X0=318,Y0=239,W=5,H=5 -> clipped to 2 writes (318,239),(319,239); done=1.
//  WIDTH=0 or X0=320 -> zero m_write pulses; done=1 within 3 cycles of START.
//  While busy: write X0=0 and a second START -> both ignored. ABORT after write 2 of a 4x4 fill
//   -> exactly 3 writes; aborted=1, done=1.
//  Assert reset during WRITE with waitrequest=1 -> m_write=0 at once; all registers read 0.

Source files
------------

// File: rtl/heat_map_pkg.sv
// Shared definitions for the heat-map rectangle fill: register map, CTRL/status bits,
// VGA geometry defaults and the fill FSM encoding.
package heat_map_pkg;

   localparam logic [2:0] REG_X0     = 3'd0;
   localparam logic [2:0] REG_Y0     = 3'd1;
   localparam logic [2:0] REG_WIDTH  = 3'd2;
   localparam logic [2:0] REG_HEIGHT = 3'd3;
   localparam logic [2:0] REG_COLOR  = 3'd4;
   localparam logic [2:0] REG_CTRL   = 3'd5;

   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;

   localparam int          VGA_SCREEN_W   = 320;
   localparam int          VGA_SCREEN_H   = 240;
   localparam int          VGA_X_SHIFT    = 1;
   localparam int          VGA_Y_SHIFT    = 10;
   localparam logic [31:0] VGA_PIXEL_BASE = 32'hC800_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } fill_state_e;

endpackage

// File: rtl/heat_map_rect_walker.sv
// Row-major x/y walker over the screen-clipped rectangle; produces the pixel byte address
// and flags for an empty rectangle and for the final pixel.
module heat_map_rect_walker
   import heat_map_pkg::*;
#(
   parameter int          COORD_W    = 10,
   parameter int          ADDR_W     = 32,
   parameter logic [31:0] PIXEL_BASE = VGA_PIXEL_BASE,
   parameter int          X_SHIFT    = VGA_X_SHIFT,
   parameter int          Y_SHIFT    = VGA_Y_SHIFT,
   parameter int          SCREEN_W   = VGA_SCREEN_W,
   parameter int          SCREEN_H   = VGA_SCREEN_H
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               advance_i,
   input  logic [COORD_W-1:0] x0_i,
   input  logic [COORD_W-1:0] y0_i,
   input  logic [COORD_W-1:0] width_i,
   input  logic [COORD_W-1:0] height_i,
   output logic               empty_o,
   output logic               last_o,
   output logic [ADDR_W-1:0]  addr_o
);

   localparam logic [COORD_W:0] SW = (COORD_W+1)'(SCREEN_W);
   localparam logic [COORD_W:0] SH = (COORD_W+1)'(SCREEN_H);

   logic [COORD_W:0] x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
   logic [COORD_W:0] x_sum, y_sum, x_inc, y_inc;
   logic             row_more, col_more;

   // One extra bit keeps X0+WIDTH from wrapping before the clip compare.
   assign x_sum = {1'b0, x0_i} + {1'b0, width_i};
   assign y_sum = {1'b0, y0_i} + {1'b0, height_i};
   assign x_inc = x_q + 1'b1;
   assign y_inc = y_q + 1'b1;

   assign row_more = x_inc < xe_q;
   assign col_more = y_inc < ye_q;
   assign last_o   = !row_more && !col_more;
   assign empty_o  = ({1'b0, x0_i} >= SW) || ({1'b0, y0_i} >= SH) ||
                     (width_i == '0) || (height_i == '0);

   assign addr_o = PIXEL_BASE + (ADDR_W'(y_q) << Y_SHIFT) + (ADDR_W'(x_q) << X_SHIFT);

   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      xe_d = xe_q;
      ye_d = ye_q;
      if (load_i) begin
         x_d  = {1'b0, x0_i};
         y_d  = {1'b0, y0_i};
         xe_d = (x_sum > SW) ? SW : x_sum;
         ye_d = (y_sum > SH) ? SH : y_sum;
      end else if (advance_i) begin
         if (row_more) begin
            x_d = x_inc;
         end else if (col_more) begin
            x_d = {1'b0, x0_i};
            y_d = y_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q  <= '0;
         y_q  <= '0;
         xe_q <= '0;
         ye_q <= '0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         xe_q <= xe_d;
         ye_q <= ye_d;
      end
   end

endmodule

// File: rtl/heat_map_rect_fill.sv
// Avalon-MM rectangle fill: slave register file plus the fill FSM that drives one master
// pixel write per clipped rectangle pixel.
module heat_map_rect_fill
   import heat_map_pkg::*;
#(
   parameter int          COORD_W    = 10,
   parameter int          COLOR_W    = 16,
   parameter int          ADDR_W     = 32,
   parameter logic [31:0] PIXEL_BASE = VGA_PIXEL_BASE,
   parameter int          X_SHIFT    = VGA_X_SHIFT,
   parameter int          Y_SHIFT    = VGA_Y_SHIFT,
   parameter int          SCREEN_W   = VGA_SCREEN_W,
   parameter int          SCREEN_H   = VGA_SCREEN_H
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   output logic [ADDR_W-1:0]  m_address,
   output logic               m_write,
   output logic [COLOR_W-1:0] m_writedata,
   input  logic               m_waitrequest,
   output logic               busy
);

   fill_state_e        state_q, state_d;
   logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic               done_q, done_d, aborted_q, aborted_d, abort_pend_q, abort_pend_d;
   logic               wr_en, start_req, abort_req, walk_load, walk_adv, empty, last;

   assign wr_en     = chipselect && !write_n;
   assign start_req = wr_en && (address == REG_CTRL) && writedata[CTRL_START];
   assign abort_req = wr_en && (address == REG_CTRL) && writedata[CTRL_ABORT];
   assign busy      = (state_q != ST_IDLE);
   assign m_writedata = color_q;

   heat_map_rect_walker #(
      .COORD_W(COORD_W), .ADDR_W(ADDR_W), .PIXEL_BASE(PIXEL_BASE), .X_SHIFT(X_SHIFT),
      .Y_SHIFT(Y_SHIFT), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
   ) u_walker (
      .clk(clk), .reset(reset), .load_i(walk_load), .advance_i(walk_adv),
      .x0_i(x0_q), .y0_i(y0_q), .width_i(w_q), .height_i(h_q),
      .empty_o(empty), .last_o(last), .addr_o(m_address)
   );

   // Geometry and colour are frozen for the whole fill.
   always_comb begin
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      color_d = color_q;
      if (wr_en && !busy) begin
         case (address)
            REG_X0:     x0_d    = writedata[COORD_W-1:0];
            REG_Y0:     y0_d    = writedata[COORD_W-1:0];
            REG_WIDTH:  w_d     = writedata[COORD_W-1:0];
            REG_HEIGHT: h_d     = writedata[COORD_W-1:0];
            REG_COLOR:  color_d = writedata[COLOR_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      done_d       = done_q;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;
      walk_load    = 1'b0;
      walk_adv     = 1'b0;
      m_write      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            abort_pend_d = 1'b0;
            if (start_req) begin
               state_d   = ST_SETUP;
               done_d    = 1'b0;
               aborted_d = 1'b0;
            end
         end
         ST_SETUP: begin
            walk_load = 1'b1;
            if (abort_req) abort_pend_d = 1'b1;
            state_d = empty ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            m_write = 1'b1;
            // A pending abort only ends the fill once the in-flight pixel is accepted.
            if (!m_waitrequest) begin
               walk_adv = 1'b1;
               if (abort_pend_q || abort_req) begin
                  aborted_d = 1'b1;
                  state_d   = ST_DONE;
               end else if (last) begin
                  state_d = ST_DONE;
               end
            end else if (abort_req) begin
               abort_pend_d = 1'b1;
            end
         end
         ST_DONE: begin
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      readdata = '0;
      case (address)
         REG_X0:     readdata[COORD_W-1:0] = x0_q;
         REG_Y0:     readdata[COORD_W-1:0] = y0_q;
         REG_WIDTH:  readdata[COORD_W-1:0] = w_q;
         REG_HEIGHT: readdata[COORD_W-1:0] = h_q;
         REG_COLOR:  readdata[COLOR_W-1:0] = color_q;
         REG_CTRL: begin
            readdata[STAT_BUSY]    = busy;
            readdata[STAT_DONE]    = done_q;
            readdata[STAT_ABORTED] = aborted_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         x0_q         <= '0;
         y0_q         <= '0;
         w_q          <= '0;
         h_q          <= '0;
         color_q      <= '0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         w_q          <= w_d;
         h_q          <= h_d;
         color_q      <= color_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
      end
   end

endmodule

// File: tb/tb_heat_map_rect_fill.sv
// Bench for heat_map_rect_fill: directed and random fills compared against a row-major
// pixel list computed from the rectangle, clip bounds and address formula.
module tb_heat_map_rect_fill;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [31:0] m_address;
   logic        m_write;
   logic [15:0] m_writedata;
   logic        m_waitrequest = 1'b0;
   logic        busy;

   int          n_vec = 0;
   int          n_err = 0;
   logic        rand_stall = 1'b0;
   logic [47:0] exp_q[$];
   logic [47:0] obs_q[$];
   logic        prev_stall = 1'b0;
   logic [47:0] prev_beat = '0;
   logic [31:0] rd;

   heat_map_rect_fill dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
      .m_waitrequest(m_waitrequest), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Record accepted beats; verify a stalled beat is held unchanged.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && m_write)
            check("stall_hold", {m_address, m_writedata}, prev_beat);
         if (m_write && !m_waitrequest)
            obs_q.push_back({m_address, m_writedata});
         prev_stall = m_write && m_waitrequest;
         prev_beat  = {m_address, m_writedata};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_stall) m_waitrequest = ($urandom_range(0, 2) == 0);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1;
      #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   // Reference: every on-screen pixel of the rectangle, row-major.
   task automatic build_expected(input int x0, input int y0, input int w, input int h,
                                 input logic [15:0] c);
      exp_q.delete();
      for (int yy = y0; yy < y0 + h && yy < 240; yy++)
         for (int xx = x0; xx < x0 + w && xx < 320; xx++)
            exp_q.push_back({32'hC800_0000 + 32'(yy) * 32'd1024 + 32'(xx) * 32'd2, c});
   endtask

   task automatic load_regs(input int x0, input int y0, input int w, input int h,
                            input logic [15:0] c);
      bus_write(3'd0, 32'(x0));
      bus_write(3'd1, 32'(y0));
      bus_write(3'd2, 32'(w));
      bus_write(3'd3, 32'(h));
      bus_write(3'd4, {16'h0, c});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000 && busy; i++) tick();
      check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic compare_fill(input string tag);
      check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s_px%0d", tag, i), {16'h0, obs_q[i]}, {16'h0, exp_q[i]});
   endtask

   task automatic run_fill(input string tag, input int x0, input int y0, input int w,
                           input int h, input logic [15:0] c, input logic stall);
      rand_stall = 1'b0; m_waitrequest = 1'b0;
      load_regs(x0, y0, w, h, c);
      build_expected(x0, y0, w, h, c);
      obs_q.delete();
      rand_stall = stall;
      bus_write(3'd5, 32'd1);
      wait_idle();
      rand_stall = 1'b0; m_waitrequest = 1'b0;
      compare_fill(tag);
      bus_read(3'd5, rd);
      check({tag, "_ctrl"}, {32'h0, rd}, 64'd2);
   endtask

   initial begin
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_m_write", {63'd0, m_write}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_m_address", {32'h0, m_address}, 64'hC800_0000);
      check("rst_m_writedata", {48'h0, m_writedata}, 64'd0);
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rd);
         check($sformatf("rst_reg%0d", a), {32'h0, rd}, 64'd0);
      end

      // Basic 2x2 fill; explicit check of the first address.
      run_fill("basic", 3, 5, 2, 2, 16'hF800, 1'b0);
      if (obs_q.size() > 0) check("basic_first_addr", {32'h0, obs_q[0][47:16]}, 64'hC800_1406);
      run_fill("basic_stall", 3, 5, 2, 2, 16'hF800, 1'b1);
      run_fill("clip", 318, 239, 5, 5, 16'h07E0, 1'b0);

      // Empty rectangles: no writes, done within three cycles of START.
      for (int k = 0; k < 2; k++) begin
         load_regs(k == 0 ? 10 : 320, 10, k == 0 ? 0 : 4, 4, 16'h1234);
         obs_q.delete();
         bus_write(3'd5, 32'd1);
         tick(); tick();
         bus_read(3'd5, rd);
         check($sformatf("empty%0d_ctrl", k), {32'h0, rd}, 64'd2);
         check($sformatf("empty%0d_count", k), 64'(obs_q.size()), 64'd0);
      end

      // Register and START writes while busy are ignored.
      load_regs(2, 3, 4, 4, 16'hABCD);
      build_expected(2, 3, 4, 4, 16'hABCD);
      obs_q.delete();
      m_waitrequest = 1'b1;
      bus_write(3'd5, 32'd1);
      tick();
      bus_write(3'd0, 32'd0);
      bus_write(3'd5, 32'd1);
      bus_read(3'd0, rd);
      check("busy_x0_kept", {32'h0, rd}, 64'd2);
      bus_read(3'd5, rd);
      check("busy_ctrl", {32'h0, rd}, 64'd1);
      m_waitrequest = 1'b0;
      wait_idle();
      compare_fill("busy_ignore");

      // Abort while pixel 3 is stalled: exactly three pixels complete.
      load_regs(10, 20, 4, 4, 16'h5555);
      build_expected(10, 20, 4, 4, 16'h5555);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      obs_q.delete();
      bus_write(3'd5, 32'd1);
      for (int i = 0; i < 50 && obs_q.size() < 2; i++) tick();
      m_waitrequest = 1'b1;
      bus_write(3'd5, 32'd2);
      tick(); tick();
      m_waitrequest = 1'b0;
      wait_idle();
      compare_fill("abort");
      bus_read(3'd5, rd);
      check("abort_ctrl", {32'h0, rd}, 64'd6);

      // Reset in the middle of a stalled write.
      load_regs(0, 0, 2, 2, 16'h0F0F);
      m_waitrequest = 1'b1;
      bus_write(3'd5, 32'd1);
      tick(); tick();
      check("pre_rst_m_write", {63'd0, m_write}, 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_m_write", {63'd0, m_write}, 64'd0);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      for (int a = 0; a < 6; a++) begin
         bus_read(3'(a), rd);
         check($sformatf("mid_rst_reg%0d", a), {32'h0, rd}, 64'd0);
      end
      m_waitrequest = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      // Random rectangles near and inside the screen with random stalls.
      for (int r = 0; r < 8; r++) begin
         run_fill($sformatf("rand%0d", r), $urandom_range(0, 330), $urandom_range(0, 250),
                  $urandom_range(0, 6), $urandom_range(0, 5), 16'($urandom), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
